// File: rtl/detector_jogada.sv
// detector_jogada: synchronizes, debounces and validates the answer buttons.
// Optional erro_multiplo output is enabled by DETECTOR_JOGADA_ERRO_EN.
module detector_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic                zera,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_feita,
`ifdef DETECTOR_JOGADA_ERRO_EN
    output logic                erro_multiplo,
`endif
    output logic [3:0]          db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BOTOES-1:0] UM = N_BOTOES'(1);

    typedef enum logic [1:0] {
        OCIOSO         = 2'd0,
        DEBOUNCE       = 2'd1,
        VALIDA         = 2'd2,
        AGUARDA_SOLTAR = 2'd3
    } estado_t;

    estado_t             estado;
    estado_t             estado_next;
    logic [N_BOTOES-1:0] sinc1;
    logic [N_BOTOES-1:0] sinc;
    logic [N_BOTOES-1:0] amostra;
    logic [N_BOTOES-1:0] amostra_next;
    logic [N_BOTOES-1:0] jogada_next;
    logic [CW-1:0]       cont;
    logic [CW-1:0]       cont_next;
    logic                feita_next;
    logic                fim_contagem;
    logic                unico;
    logic                algum;
`ifdef DETECTOR_JOGADA_ERRO_EN
    logic                erro_next;
`endif

    // Two-flop synchronizer for the raw asynchronous buttons
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1 <= '0;
            sinc  <= '0;
        end else begin
            sinc1 <= botoes;
            sinc  <= sinc1;
        end
    end

    assign fim_contagem = (cont == CNT_MAX);
    assign algum        = (sinc != '0);
    assign unico        = (amostra != '0) &&
                          ((amostra & (amostra - UM)) == '0);

    // State, counter, sample and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            cont         <= '0;
            amostra      <= '0;
            jogada       <= '0;
            jogada_feita <= 1'b0;
`ifdef DETECTOR_JOGADA_ERRO_EN
            erro_multiplo <= 1'b0;
`endif
        end else begin
            estado       <= estado_next;
            cont         <= cont_next;
            amostra      <= amostra_next;
            jogada       <= jogada_next;
            jogada_feita <= feita_next;
`ifdef DETECTOR_JOGADA_ERRO_EN
            erro_multiplo <= erro_next;
`endif
        end
    end

    // Next-state and next-output logic; zera overrides every transition
    always_comb begin
        estado_next  = estado;
        cont_next    = cont;
        amostra_next = amostra;
        jogada_next  = jogada;
        feita_next   = 1'b0;
`ifdef DETECTOR_JOGADA_ERRO_EN
        erro_next    = 1'b0;
`endif
        if (zera) begin
            jogada_next = '0;
            cont_next   = '0;
            estado_next = AGUARDA_SOLTAR;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (habilita && algum) begin
                        amostra_next = sinc;
                        cont_next    = '0;
                        estado_next  = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!habilita || (sinc != amostra)) begin
                        estado_next = OCIOSO;
                    end else if (fim_contagem) begin
                        estado_next = VALIDA;
                    end else begin
                        cont_next = cont + 1'b1;
                    end
                end
                VALIDA: begin
                    if (unico) begin
                        jogada_next = amostra;
                        feita_next  = 1'b1;
                    end
`ifdef DETECTOR_JOGADA_ERRO_EN
                    else begin
                        erro_next = 1'b1;
                    end
`endif
                    cont_next   = '0;
                    estado_next = AGUARDA_SOLTAR;
                end
                AGUARDA_SOLTAR: begin
                    if (algum) begin
                        cont_next = '0;
                    end else if (fim_contagem) begin
                        estado_next = OCIOSO;
                    end else begin
                        cont_next = cont + 1'b1;
                    end
                end
                default: begin
                    estado_next = OCIOSO;
                end
            endcase
        end
    end

    // Debug view of the state code
    assign db_estado = {2'b00, estado};

endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed stimulus with a queue of expected plays.
// Checks pulse timing/code, state codes, zera and async reset.
module tb_detector_jogada;

    localparam int N = 4;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         habilita = 1'b0;
    logic         zera = 1'b0;
    logic [N-1:0] botoes = '0;
    logic [N-1:0] jogada;
    logic         jogada_feita;
    logic [3:0]   db_estado;
`ifdef DETECTOR_JOGADA_ERRO_EN
    logic         erro_multiplo;
`endif

    typedef struct {
        logic [N-1:0] val;
        int           at;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_erro = 0;

    detector_jogada #(
        .N_BOTOES(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock(clock),
        .reset(reset),
        .habilita(habilita),
        .zera(zera),
        .botoes(botoes),
        .jogada(jogada),
        .jogada_feita(jogada_feita),
`ifdef DETECTOR_JOGADA_ERRO_EN
        .erro_multiplo(erro_multiplo),
`endif
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_play(logic [N-1:0] v);
        exp_t e;
        e.val = v;
        e.at  = cyc + D + 4;
        q.push_back(e);
    endtask

    // Scoreboard: every pulse must match the oldest expected play
    always @(negedge clock) begin
        if (jogada_feita === 1'b1) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: observed jogada=%0h at cyc=%0d expected no pulse",
                       jogada, cyc);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_code", 32'(jogada), 32'(e.val));
                chk("pulse_time", 32'(cyc), 32'(e.at));
            end
        end
`ifdef DETECTOR_JOGADA_ERRO_EN
        if (erro_multiplo === 1'b1) n_erro++;
`endif
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_jogada", 32'(jogada), 32'h0);
        chk("rst_feita", 32'(jogada_feita), 32'h0);
        chk("rst_estado", 32'(db_estado), 32'h0);
        reset = 1'b1;
        tick(2);

        // Clean press held 20 cycles
        habilita = 1'b1;
        botoes = 4'b0100;
        expect_play(4'b0100);
        tick(20);
        chk("clean_estado_held", 32'(db_estado), 32'h3);
        chk("clean_jogada", 32'(jogada), 32'h4);
        botoes = 4'b0000;
        tick(5);
        chk("clean_release_wait", 32'(db_estado), 32'h3);
        tick(1);
        chk("clean_release_idle", 32'(db_estado), 32'h0);
        tick(2);

        // Bounce then stable hold
        for (int i = 0; i < 5; i++) begin
            botoes = (i % 2 == 1) ? 4'b0010 : 4'b0000;
            tick(2);
        end
        chk("bounce_no_pulse", 32'(jogada), 32'h4);
        botoes = 4'b0010;
        expect_play(4'b0010);
        tick(12);
        botoes = 4'b0000;
        tick(10);
        chk("bounce_jogada", 32'(jogada), 32'h2);
        chk("bounce_idle", 32'(db_estado), 32'h0);

        // Two buttons together: discarded
        botoes = 4'b0011;
        tick(12);
        chk("multi_estado", 32'(db_estado), 32'h3);
        chk("multi_keep", 32'(jogada), 32'h2);
        botoes = 4'b0000;
        tick(10);
        chk("multi_idle", 32'(db_estado), 32'h0);

        // Detection disabled
        habilita = 1'b0;
        botoes = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("disabled_estado", 32'(db_estado), 32'h0);
        end

        // Enable mid-hold, then drop during debounce
        habilita = 1'b1;
        tick(1);
        chk("hab_debounce", 32'(db_estado), 32'h1);
        tick(1);
        habilita = 1'b0;
        tick(1);
        chk("hab_drop_idle", 32'(db_estado), 32'h0);
        botoes = 4'b0000;
        tick(4);

        // zera while a button is held
        habilita = 1'b1;
        botoes = 4'b0001;
        expect_play(4'b0001);
        tick(12);
        chk("zera_pre_jogada", 32'(jogada), 32'h1);
        zera = 1'b1;
        tick(1);
        zera = 1'b0;
        chk("zera_jogada", 32'(jogada), 32'h0);
        chk("zera_estado", 32'(db_estado), 32'h3);
        chk("zera_feita", 32'(jogada_feita), 32'h0);
        tick(10);
        chk("zera_held_estado", 32'(db_estado), 32'h3);
        botoes = 4'b0000;
        tick(5);
        chk("zera_release_wait", 32'(db_estado), 32'h3);
        tick(1);
        chk("zera_release_idle", 32'(db_estado), 32'h0);
        botoes = 4'b0001;
        expect_play(4'b0001);
        tick(12);
        chk("repress_jogada", 32'(jogada), 32'h1);
        botoes = 4'b0000;
        tick(8);

        // Asynchronous reset in the middle of debounce
        botoes = 4'b1000;
        tick(4);
        chk("arst_pre_estado", 32'(db_estado), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_jogada", 32'(jogada), 32'h0);
        chk("arst_feita", 32'(jogada_feita), 32'h0);
        chk("arst_estado", 32'(db_estado), 32'h0);
        @(negedge clock);
        botoes = 4'b0000;
        reset = 1'b1;
        tick(4);
        chk("arst_after_estado", 32'(db_estado), 32'h0);

        chk("pending_plays", 32'(q.size()), 32'h0);
`ifdef DETECTOR_JOGADA_ERRO_EN
        chk("erro_count", 32'(n_erro), 32'h1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
